// File: rtl/ab_seg_if.sv
// ab_seg_if: bundles the control, data and result signals of one address-bus segment.
// The master side drives the controls; the slave side (ab_seg) produces AD/AB/PC/CO/fix.
interface ab_seg_if #(
    parameter int WIDTH = 8
);
    logic             rdy;
    logic             CI;
    logic [WIDTH-1:0] DB;
    logic [3:0]       op;
    logic             defer;
    logic             ld_pc;
    logic             inc_pc;
    logic [WIDTH-1:0] AD;
    logic [WIDTH-1:0] AB;
    logic [WIDTH-1:0] PC;
    logic             CO;
    logic             fix;

    modport master (
        output rdy, CI, DB, op, defer, ld_pc, inc_pc,
        input  AD, AB, PC, CO, fix
    );

    modport slave (
        input  rdy, CI, DB, op, defer, ld_pc, inc_pc,
        output AD, AB, PC, CO, fix
    );
endinterface

// File: rtl/ab_seg.sv
// ab_seg: one WIDTH-bit slice of the 65C02 address unit (base mux, small adder, AB and PC registers).
// Define AB_SEG_FIX_EN to add the deferred page-cross fix-up state (one dummy cycle before a carry).
module ab_seg #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] RESET_AB = '0,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic     clk,
    input logic     RST,
    ab_seg_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_ab;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_normAd;
    logic             w_normCo;
    logic [WIDTH-1:0] w_ad;
    logic             w_co;
    logic             w_fixState;
    logic             w_deferReq;

    always_comb begin
        case (bus.op[3:2])
            2'b00:   w_base = '0;
            2'b01:   w_base = r_ab;
            2'b10:   w_base = r_pc;
            default: w_base = bus.DB;
        endcase
    end

    // CO flags a wrap out of this segment so the next segment up can chain on it.
    always_comb begin
        w_normAd = w_base;
        w_normCo = 1'b0;
        case (bus.op[1:0])
            2'b01: begin
                w_normAd = w_base + ONE;
                w_normCo = &w_base;
            end
            2'b10: begin
                w_normAd = bus.CI ? (w_base + ONE) : w_base;
                w_normCo = bus.CI & (&w_base);
            end
            2'b11: begin
                w_normAd = bus.CI ? w_base : (w_base - ONE);
                w_normCo = ~bus.CI & ~(|w_base);
            end
            default: ;
        endcase
    end

`ifdef AB_SEG_FIX_EN
    typedef enum logic {
        IDLE,
        FIX
    } state_t;

    state_t r_state;
    state_t w_nextState;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    // A pending carry is parked for one cycle; the FIX cycle then applies it to AB.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_deferReq) w_nextState = FIX;
            FIX:  if (bus.rdy)    w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_fixState = (r_state == FIX);
        w_deferReq = (r_state == IDLE) & bus.rdy & bus.defer & (bus.op[1:0] == 2'b10) & bus.CI;
    end
`else
    assign w_fixState = 1'b0;
    assign w_deferReq = 1'b0;
`endif

    always_comb begin
        w_ad = w_normAd;
        w_co = w_normCo;
        if (w_fixState) begin
            w_ad = r_ab + ONE;
            w_co = &r_ab;
        end else if (w_deferReq) begin
            w_ad = w_base;
            w_co = 1'b0;
        end
    end

    // PC loads from the pre-edge AB, optionally bumped by one.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_ab <= RESET_AB;
            r_pc <= RESET_PC;
        end else if (bus.rdy) begin
            r_ab <= w_ad;
            if (bus.ld_pc) r_pc <= bus.inc_pc ? (r_ab + ONE) : r_ab;
        end
    end

    assign bus.AD  = w_ad;
    assign bus.CO  = w_co;
    assign bus.AB  = r_ab;
    assign bus.PC  = r_pc;
    assign bus.fix = w_fixState;
endmodule

// File: tb/tb_ab_seg.sv
// tb_ab_seg: drives an 8-bit and a 12-bit ab_seg with directed and random stimulus and
// scoreboards them against an arithmetic reference model (honours AB_SEG_FIX_EN).
module tb_ab_seg;
`ifdef AB_SEG_FIX_EN
    localparam bit FIX_EN = 1'b1;
`else
    localparam bit FIX_EN = 1'b0;
`endif
    localparam int RESET_AB8  = 'h00;
    localparam int RESET_PC8  = 'hFF;
    localparam int RESET_AB12 = 'hFFE;
    localparam int RESET_PC12 = 'h000;

    typedef struct {
        int ab;
        int pc;
        bit fixSt;
    } mstate_t;

    typedef struct {
        int ad;
        bit co;
        bit fix;
        int ab;
        int pc;
    } exp_t;

    typedef struct {
        bit         rdy;
        bit         ci;
        bit         defer;
        bit         ldPc;
        bit         incPc;
        logic [3:0] op;
        int         db;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ab_seg_if #(.WIDTH(8))  bus8();
    ab_seg_if #(.WIDTH(12)) bus12();

    ab_seg #(.WIDTH(8), .RESET_AB(8'h00), .RESET_PC(8'hFF)) dut8 (
        .clk (clk),
        .RST (rst),
        .bus (bus8)
    );

    ab_seg #(.WIDTH(12), .RESET_AB(12'hFFE), .RESET_PC(12'h000)) dut12 (
        .clk (clk),
        .RST (rst),
        .bus (bus12)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    exp_t q8[$];
    exp_t q12[$];
    mstate_t st8;
    mstate_t st12;

    function automatic bit isDeferReq(stim_t s);
        return FIX_EN && s.rdy && s.defer && (s.op[1:0] == 2'b10) && s.ci;
    endfunction

    // Expected outputs from plain modular arithmetic on the segment value.
    function automatic exp_t predict(int w, mstate_t st, stim_t s);
        int   m = 1 << w;
        int   base;
        int   delta;
        int   raw;
        exp_t e;
        case (s.op[3:2])
            2'b00:   base = 0;
            2'b01:   base = st.ab;
            2'b10:   base = st.pc;
            default: base = s.db % m;
        endcase
        if (st.fixSt) begin
            raw = st.ab + 1;
        end else if (isDeferReq(s)) begin
            raw = base;
        end else begin
            case (s.op[1:0])
                2'b00:   delta = 0;
                2'b01:   delta = 1;
                2'b10:   delta = int'(s.ci);
                default: delta = int'(s.ci) - 1;
            endcase
            raw = base + delta;
        end
        e.co  = (raw >= m) || (raw < 0);
        e.ad  = (raw + m) % m;
        e.fix = st.fixSt;
        e.ab  = st.ab;
        e.pc  = st.pc;
        return e;
    endfunction

    function automatic mstate_t advance(int w, mstate_t st, stim_t s, exp_t e);
        int      m  = 1 << w;
        mstate_t ns = st;
        if (s.rdy) ns.ab = e.ad;
        if (s.rdy && s.ldPc) ns.pc = (st.ab + int'(s.incPc)) % m;
        if (st.fixSt) begin
            if (s.rdy) ns.fixSt = 1'b0;
        end else if (isDeferReq(s)) begin
            ns.fixSt = 1'b1;
        end
        return ns;
    endfunction

    function automatic stim_t mk(bit rdy, logic [3:0] op, bit ci, bit defer, bit ldPc, bit incPc, int db);
        stim_t s;
        s.rdy = rdy; s.op = op; s.ci = ci; s.defer = defer;
        s.ldPc = ldPc; s.incPc = incPc; s.db = db;
        return s;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
        checkCount++;
        if (act !== expv) $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        else passCount++;
    endtask

    // Drive one cycle's inputs just after the rising edge and queue the expected response.
    task automatic applyStimulus(stim_t s);
        exp_t e8;
        exp_t e12;
        @(posedge clk);
        #1;
        bus8.rdy  = s.rdy;  bus8.op  = s.op;  bus8.CI  = s.ci;  bus8.defer  = s.defer;
        bus8.ld_pc = s.ldPc; bus8.inc_pc = s.incPc; bus8.DB = 8'(s.db);
        bus12.rdy = s.rdy;  bus12.op = s.op;  bus12.CI = s.ci;  bus12.defer = s.defer;
        bus12.ld_pc = s.ldPc; bus12.inc_pc = s.incPc; bus12.DB = 12'(s.db);
        e8  = predict(8, st8, s);
        e12 = predict(12, st12, s);
        q8.push_back(e8);
        q12.push_back(e12);
        st8  = advance(8, st8, s, e8);
        st12 = advance(12, st12, s, e12);
    endtask

    task automatic resetModels();
        st8.ab  = RESET_AB8;  st8.pc  = RESET_PC8;  st8.fixSt  = 1'b0;
        st12.ab = RESET_AB12; st12.pc = RESET_PC12; st12.fixSt = 1'b0;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must fall back without a clock edge.
    task automatic resetMidRun();
        @(negedge clk);
        #1;
        bus8.rdy = 1'b0;
        bus12.rdy = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_fix8",  32'(bus8.fix),  32'd0);
        checkOutput("rst_ab8",   32'(bus8.AB),   32'(RESET_AB8));
        checkOutput("rst_pc8",   32'(bus8.PC),   32'(RESET_PC8));
        checkOutput("rst_fix12", 32'(bus12.fix), 32'd0);
        checkOutput("rst_ab12",  32'(bus12.AB),  32'(RESET_AB12));
        resetModels();
        #1;
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                checkOutput("AD8",  32'(bus8.AD),  32'(e.ad));
                checkOutput("CO8",  32'(bus8.CO),  32'(e.co));
                checkOutput("fix8", 32'(bus8.fix), 32'(e.fix));
                checkOutput("AB8",  32'(bus8.AB),  32'(e.ab));
                checkOutput("PC8",  32'(bus8.PC),  32'(e.pc));
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                checkOutput("AD12",  32'(bus12.AD),  32'(e.ad));
                checkOutput("CO12",  32'(bus12.CO),  32'(e.co));
                checkOutput("fix12", 32'(bus12.fix), 32'(e.fix));
                checkOutput("AB12",  32'(bus12.AB),  32'(e.ab));
                checkOutput("PC12",  32'(bus12.PC),  32'(e.pc));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        stim_t s;
        int    dbSel;
        bus8.rdy = 1'b0;  bus8.op = 4'h0;  bus8.CI = 1'b0;  bus8.defer = 1'b0;
        bus8.ld_pc = 1'b0;  bus8.inc_pc = 1'b0;  bus8.DB = '0;
        bus12.rdy = 1'b0; bus12.op = 4'h0; bus12.CI = 1'b0; bus12.defer = 1'b0;
        bus12.ld_pc = 1'b0; bus12.inc_pc = 1'b0; bus12.DB = '0;
        resetModels();

        repeat (2) @(negedge clk);
        #1;
        checkOutput("init_ab8",   32'(bus8.AB),   32'(RESET_AB8));
        checkOutput("init_pc8",   32'(bus8.PC),   32'(RESET_PC8));
        checkOutput("init_fix8",  32'(bus8.fix),  32'd0);
        checkOutput("init_ab12",  32'(bus12.AB),  32'(RESET_AB12));
        rst = 1'b0;

        // Frozen while rdy is low.
        applyStimulus(mk(0, 4'b1101, 0, 0, 1, 1, 'h55));
        applyStimulus(mk(0, 4'b0101, 0, 0, 1, 0, 'h00));

        // Base/add sweep around DB=3C, committing only the -1+CI case.
        applyStimulus(mk(0, 4'b1100, 0, 0, 0, 0, 'h3C));
        applyStimulus(mk(0, 4'b1101, 0, 0, 0, 0, 'h3C));
        applyStimulus(mk(0, 4'b1110, 1, 0, 0, 0, 'h3C));
        applyStimulus(mk(1, 4'b1111, 0, 0, 0, 0, 'h3C));
        applyStimulus(mk(0, 4'b0000, 0, 0, 0, 0, 'h3C));

        // Wrap in both directions.
        applyStimulus(mk(1, 4'b1100, 0, 0, 0, 0, 'hFFF));
        applyStimulus(mk(1, 4'b0101, 0, 0, 0, 0, 'h000));
        applyStimulus(mk(1, 4'b0111, 0, 0, 0, 0, 'h000));
        applyStimulus(mk(0, 4'b1110, 1, 0, 0, 0, 'hFFF));

        // PC load from AB=12 with increment, then a load attempt while frozen.
        applyStimulus(mk(1, 4'b1100, 0, 0, 0, 0, 'h12));
        applyStimulus(mk(1, 4'b0100, 0, 0, 1, 1, 'h00));
        applyStimulus(mk(0, 4'b1100, 0, 0, 1, 0, 'h77));
        applyStimulus(mk(0, 4'b0100, 0, 0, 0, 0, 'h00));

        // Deferred carry with a two-cycle stall inside FIX.
        applyStimulus(mk(1, 4'b1110, 1, 1, 0, 0, 'h20));
        applyStimulus(mk(0, 4'b1110, 0, 1, 0, 0, 'h99));
        applyStimulus(mk(0, 4'b1111, 1, 1, 0, 0, 'h99));
        applyStimulus(mk(1, 4'b1110, 1, 1, 1, 1, 'h99));
        applyStimulus(mk(0, 4'b0100, 0, 0, 0, 0, 'h00));

        // Reset while parked in FIX, then resume from RESET_AB.
        applyStimulus(mk(1, 4'b1110, 1, 1, 0, 0, 'h50));
        applyStimulus(mk(0, 4'b0000, 0, 0, 0, 0, 'h00));
        resetMidRun();
        applyStimulus(mk(1, 4'b0101, 0, 0, 0, 0, 'h00));

        for (int i = 0; i < 400; i++) begin
            dbSel = int'($urandom_range(3));
            case (dbSel)
                0:       s.db = 0;
                1:       s.db = 'hFFF;
                default: s.db = int'($urandom_range(4095));
            endcase
            s.op    = 4'($urandom_range(15));
            s.rdy   = ($urandom_range(3) != 0);
            s.ci    = 1'($urandom_range(1));
            s.defer = 1'($urandom_range(1));
            s.ldPc  = ($urandom_range(2) == 0);
            s.incPc = 1'($urandom_range(1));
            applyStimulus(s);
            if (i == 200) resetMidRun();
        end

        @(negedge clk);
        #1;
        checkOutput("q8_drained",  32'(q8.size()),  32'd0);
        checkOutput("q12_drained", 32'(q12.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/ab_seg.md
# ab_seg

Parametrised address-bus segment for the 65C02 datapath, generalising the fixed 8-bit high-byte address unit. It selects a base value (zero, current AB, PC or DB) and adds 0, +1, +CI or −1+CI to produce the next address segment. It holds the registered address (AB) and the program-counter segment (PC), and outputs a wrap/carry flag so segments can be chained. As a new feature, an optional deferred page-cross fix-up state machine inserts one extra cycle before a carry is applied, for NMOS-style dummy-access timing.

## Interface
- WIDTH, 8: segment width in bits (≥2).
- RESET_AB, 0: AB value on reset.
- RESET_PC, 0: PC value on reset.

- clk  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; 0 freezes AB, PC and the FSM.
- CI  in  1  carry from the lower segment.
- DB  in  WIDTH  data bus.
- op  in  4  [3:2] base select, [1:0] add select.
- defer  in  1  request deferred carry (effective only with fix-up compiled in).
- ld_pc  in  1  load PC.
- inc_pc  in  1  increment during PC load.
- AD  out  WIDTH  unregistered next address.
- AB  out  WIDTH  registered address.
- PC  out  WIDTH  program counter segment.
- CO  out  1  wrap flag of the current AD computation (unregistered).
- fix  out  1  high while in FIX state (stall/dummy-cycle indicator).

## Operation
- Reset: AB=RESET_AB, PC=RESET_PC, FSM=IDLE, fix=0.
- Base select, op[3:2]:
  - 00 = 0
  - 01 = AB
  - 10 = PC
  - 11 = DB
- Add select, op[1:0]:
  - 00 = +0
  - 01 = +1
  - 10 = +CI
  - 11 = −1+CI (i.e. −1 if CI=0, +0 if CI=1)
- Arithmetic is modulo 2^WIDTH.
- CO = 1 when the result wraps:
  - +1 or +CI: base = all-ones and the increment is 1.
  - −1+CI: CI=0 and base = 0 (borrow).
  - Otherwise CO = 0.
- AB <= AD when rdy=1.
- PC <= AB + inc_pc (modulo 2^WIDTH) when ld_pc & rdy. This uses the AB value before the edge.
- FSM states: IDLE, FIX.
  - IDLE → FIX: rdy & defer & op[1:0]=10 & CI=1. In this cycle AD = base (carry suppressed) and CO=0.
  - FIX: fix=1. AD = AB + 1, regardless of op and CI. CO reflects this increment. On rdy, AB <= AD and the FSM returns to IDLE.
  - All other conditions: stay IDLE, with normal AD.
  - defer and CI are ignored while in FIX.
- ld_pc is honoured in every state.
- Simultaneous FIX exit and a new deferred request: the FIX increment wins. The new request is not evaluated until IDLE.

## Timing
- AD, CO and fix are combinational from inputs, AB, PC and the FSM state. Zero latency.
- AB and PC update one edge after the inputs are presented with rdy=1.
- A deferred carry costs exactly one extra rdy-qualified cycle.
- rdy=0 in FIX: hold FIX, fix stays 1, and AD stays AB+1.
- RST asserted at any time (including mid-FIX): immediate return to reset values. fix drops without waiting for clk.
- The first rising edge after RST deasserts behaves normally.

## Configuration
- AB_SEG_FIX_EN defined: the FIX state, the defer input function and the fix output are implemented as above.
- AB_SEG_FIX_EN undefined:
  - defer is ignored.
  - fix is tied 0.
  - The FSM is absent and CI is always applied in the same cycle.
  - Behaviour is otherwise identical.

## Test plan
- Reset: hold RST with RESET_PC=8'hFF → AB=00, PC=FF, fix=0. Deassert and clock with rdy=0 → values unchanged.
- Mux/add sweep (WIDTH=8): DB=3C with op=1100 → AD=3C. op=1101 → 3D. op=1110 with CI=1 → 3D. op=1111 with CI=0 → 3B. op=0000 → 00. Clock → AB=3B after the last case.
- Wrap: AB=FF, op=0101 → AD=00, CO=1. AB=00, op=0111 with CI=0 → AD=FF, CO=1. WIDTH=12: AB=FFF, +1 → 000, CO=1.
- PC load: AB=12, ld_pc=1, inc_pc=1 → PC=13 next edge. With rdy=0 → PC unchanged.
- Deferred fix-up (AB_SEG_FIX_EN): DB=20, op=1110, CI=1, defer=1 → AD=20, AB=20, fix=1. Hold rdy=0 for 2 cycles → fix stays 1. Then rdy=1 → AB=21, fix=0. Repeat with the macro undefined → AD=21 immediately, fix=0.
- Reset mid-FIX: assert RST while fix=1 → fix=0 and AB=RESET_AB asynchronously. The next op=0101 yields AD=RESET_AB+1.
